// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential signed divider.
//   DATA_W : operand / result width
//   ITERS  : number of restoring steps (one per quotient bit)
//   CNT_W  : width of the step counter
//   state_t: control FSM encoding
package seq_div_pkg;
    localparam int DATA_W = 32;
    localparam int ITERS  = 32;
    localparam int CNT_W  = $clog2(ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/cond_neg.sv
// Conditional two's-complement negation.
//   a   : input value
//   neg : 1 -> y = -a, 0 -> y = a
//   y   : result (same width as a)
module cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);
    // Invert every bit under control, then add the control bit back in.
    assign y = (a ^ {W{neg}}) + {{(W-1){1'b0}}, neg};
endmodule

// File: rtl/seq_div.sv
// Sequential signed 32-bit restoring divider (one quotient bit per cycle).
//   clock, reset          : clock and synchronous active-low reset
//   data_operandA/B       : dividend / divisor, sampled on the start edge
//   ctrl_DIV              : start request, honoured only in IDLE
//   data_result           : registered quotient (truncated toward zero)
//   data_remainder        : registered remainder (sign of dividend)
//   data_exception        : registered divide-by-zero / overflow flag
//   data_resultRDY        : one-cycle completion pulse
//   busy                  : high whenever an operation is in flight
module seq_div
    import seq_div_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    input  logic              ctrl_DIV,
    output logic [DATA_W-1:0] data_result,
    output logic [DATA_W-1:0] data_remainder,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);
    state_t            state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] divisor, quo, rem;
    logic              signA, signQ, divZero, excPend;

    logic [DATA_W-1:0] magA, magB, fixQuo, fixRem;
    logic [DATA_W:0]   remShift, trial;

    cond_neg #(.W(DATA_W)) uMagA (.a(data_operandA), .neg(data_operandA[DATA_W-1]), .y(magA));
    cond_neg #(.W(DATA_W)) uMagB (.a(data_operandB), .neg(data_operandB[DATA_W-1]), .y(magB));
    cond_neg #(.W(DATA_W)) uFixQ (.a(quo), .neg(signQ), .y(fixQuo));
    cond_neg #(.W(DATA_W)) uFixR (.a(rem), .neg(signA), .y(fixRem));

    // 33-bit trial subtraction; bit DATA_W set means the difference went negative.
    assign remShift = {rem, quo[DATA_W-1]};
    assign trial    = remShift - {1'b0, divisor};

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (ctrl_DIV) nextState = RUN;
            RUN:  if (cnt == CNT_W'(ITERS - 1)) nextState = FIX;
            FIX:  nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt            <= '0;
            divisor        <= '0;
            quo            <= '0;
            rem            <= '0;
            signA          <= 1'b0;
            signQ          <= 1'b0;
            divZero        <= 1'b0;
            excPend        <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: if (ctrl_DIV) begin
                    divisor <= magB;
                    quo     <= magA;
                    rem     <= '0;
                    cnt     <= '0;
                    signA   <= data_operandA[DATA_W-1];
                    signQ   <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
                    divZero <= (data_operandB == '0);
                    excPend <= (data_operandB == '0) ||
                               (data_operandA == {1'b1, {(DATA_W-1){1'b0}}} &&
                                data_operandB == {DATA_W{1'b1}});
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (!trial[DATA_W]) begin
                        rem <= trial[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= remShift[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b0};
                    end
                end
                FIX: begin
                    // With a zero divisor every dividend bit ends up in rem,
                    // so the sign-fixed remainder is the original dividend.
                    data_result    <= divZero ? '0 : fixQuo;
                    data_remainder <= fixRem;
                    data_exception <= excPend;
                    data_resultRDY <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_DIV;
    logic [31:0] data_result, data_remainder;
    logic        data_exception, data_resultRDY, busy;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] rem;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;

    seq_div dut (
        .clock(clock), .reset(reset),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_DIV(ctrl_DIV),
        .data_result(data_result), .data_remainder(data_remainder),
        .data_exception(data_exception), .data_resultRDY(data_resultRDY),
        .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_rdy", {31'b0, data_resultRDY}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.name, "_result"}, data_result, e.res);
                check({e.name, "_remainder"}, data_remainder, e.rem);
                check({e.name, "_exception"}, {31'b0, data_exception}, {31'b0, e.exc});
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue a start; expected completion is the cycle after the 33rd edge.
    task automatic startOp(input logic [31:0] a, input logic [31:0] b, input bit track,
                           input string name, input logic [31:0] res,
                           input logic [31:0] rem, input logic exc);
        exp_t e;
        @(posedge clock); #1;
        data_operandA = a; data_operandB = b; ctrl_DIV = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom;
        if (track) begin
            e.name = name; e.res = res; e.rem = rem; e.exc = exc; e.cyc = cyc + 33;
            sbq.push_back(e);
        end
        check({name, "_busy"}, {31'b0, busy}, 32'd1);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (n >= 60) check({name, "_timeout"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic checkCleared(input string name);
        check({name, "_busy"}, {31'b0, busy}, 32'd0);
        check({name, "_rdy"}, {31'b0, data_resultRDY}, 32'd0);
        check({name, "_result"}, data_result, 32'd0);
        check({name, "_remainder"}, data_remainder, 32'd0);
        check({name, "_exception"}, {31'b0, data_exception}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ctrl_DIV = 1'b0; data_operandA = '0; data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        checkCleared("reset");
        reset = 1'b1;

        startOp(32'd100, 32'd7, 1, "p100_7", 32'd14, 32'd2, 1'b0);
        waitIdle("p100_7");
        startOp(32'hFFFFFF9C, 32'd7, 1, "m100_7", 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        waitIdle("m100_7");
        startOp(32'd5, 32'd0, 1, "div0", 32'd0, 32'd5, 1'b1);
        waitIdle("div0");
        startOp(32'h80000000, 32'hFFFFFFFF, 1, "ovf", 32'h80000000, 32'd0, 1'b1);
        waitIdle("ovf");
        startOp(32'h80000000, 32'd2, 1, "min_2", 32'hC0000000, 32'd0, 1'b0);
        waitIdle("min_2");

        // Second start during RUN step 10 must be dropped.
        startOp(32'd50, 32'd5, 1, "p50_5", 32'd10, 32'd0, 1'b0);
        repeat (9) @(posedge clock);
        #1; ctrl_DIV = 1'b1; data_operandA = 32'd9; data_operandB = 32'd3;
        @(posedge clock); #1; ctrl_DIV = 1'b0;
        waitIdle("p50_5");
        repeat (40) @(posedge clock);
        #1;
        check("hold_result", data_result, 32'd10);
        check("hold_busy", {31'b0, busy}, 32'd0);

        // Reset at RUN step 16, with a simultaneous start request.
        startOp(32'd1000, 32'd3, 0, "abort", 32'd0, 32'd0, 1'b0);
        repeat (15) @(posedge clock);
        #1; reset = 1'b0; ctrl_DIV = 1'b1;
        @(posedge clock); #1;
        checkCleared("abort");
        reset = 1'b1; ctrl_DIV = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("abort_idle", {31'b0, busy}, 32'd0);

        startOp(32'hFFFFFFF9, 32'hFFFFFFFE, 1, "m7_m2", 32'd3, 32'hFFFFFFFF, 1'b0);
        waitIdle("m7_m2");
        repeat (3) @(posedge clock);
        #1;
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all state changes on the rising edge of clock.
REQ-002 clock  input  1  system clock.
REQ-003 reset  input  1  synchronous active-low reset; 0 at a rising edge resets the block.
REQ-004 data_operandA  input  32  signed two's-complement dividend; sampled only on the start edge.
REQ-005 data_operandB  input  32  signed two's-complement divisor; sampled only on the start edge.
REQ-006 ctrl_DIV  input  1  start request; honoured only in IDLE.
REQ-007 data_result  output  32  registered signed quotient.
REQ-008 data_remainder  output  32  registered signed remainder.
REQ-009 data_exception  output  1  registered; 1 on divide-by-zero or overflow.
REQ-010 data_resultRDY  output  1  registered one-cycle completion pulse.
REQ-011 busy  output  1  1 in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, RUN, FIX, DONE.
REQ-013 IDLE: ctrl_DIV=1 at an edge SHALL latch |A|, |B|, sign(A), sign(A) xor sign(B), clear the 32-bit partial remainder and 5-bit counter, and enter RUN.
REQ-014 RUN: each edge SHALL perform one restoring step: shift {rem,quo} left 1, trial-subtract |B| from rem as a 33-bit operation, keep the difference and set the quotient LSB to 1 if it is non-negative, else restore and set it to 0.
REQ-015 RUN SHALL last exactly 32 edges; the counter increments each step and wraps from 31 to 0 on the transition to FIX.
REQ-016 FIX: one edge SHALL negate the quotient if the signs differ, negate the remainder if sign(A)=1, write data_result, data_remainder and data_exception, and enter DONE.
REQ-017 DONE: data_resultRDY SHALL be 1 for exactly this one cycle; the next edge SHALL return to IDLE.
REQ-018 Latency: data_resultRDY SHALL be high in the cycle following the 33rd edge after the edge that sampled ctrl_DIV.
REQ-019 Divisor = 0: SHALL still run full latency; data_result=0, data_remainder=dividend, data_exception=1.
REQ-020 A = 0x80000000, B = 0xFFFFFFFF: data_result=0x80000000, data_remainder=0, data_exception=1.
REQ-021 Otherwise data_exception SHALL be 0; the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-022 ctrl_DIV in RUN, FIX or DONE SHALL be ignored, with no queuing; a start is accepted only in IDLE.
REQ-023 data_result, data_remainder and data_exception SHALL hold their values until the FIX edge of the next operation.
REQ-024 Operand changes after the start edge SHALL NOT affect the operation in progress.
REQ-025 Magnitude of 0x80000000 SHALL be treated as unsigned 2^31, using a 32-bit unsigned datapath.

Reset
REQ-026 reset=0 at any edge, including mid-operation, SHALL force IDLE, counter=0, data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-027 An operation aborted by reset SHALL produce no data_resultRDY pulse.
REQ-028 ctrl_DIV=1 at the same edge as reset=0 SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the state encoding, the data width (32) and the iteration count (32).
REQ-030 One sub-module, cond_neg, SHALL provide conditional two's-complement negation: xor each bit with the control, then add the control. It is instantiated for operand magnitude and for result sign fix.
REQ-031 Control FSM and datapath SHALL reside in seq_div; no other sub-modules.

Verification
REQ-032 A=100, B=7, start -> 33 edges later rdy=1, result=14, remainder=2, exception=0.
REQ-033 A=-100 (0xFFFFFF9C), B=7 -> result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2).
REQ-034 A=5, B=0 -> result=0, remainder=5, exception=1, same latency.
REQ-035 A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, remainder=0, exception=1; A=0x80000000, B=2 -> result=0xC0000000, exception=0.
REQ-036 A=50, B=5 started, then ctrl_DIV pulsed at RUN step 10 with A=9, B=3 -> single rdy pulse with result=10; the second start is ignored.
REQ-037 Reset asserted at RUN step 16 -> next cycle busy=0, outputs 0, no rdy pulse; a fresh start of A=-7, B=-2 then yields result=3, remainder=-1.
